// File: rtl/placar_pkg.sv
// Shared types and constants for the scoreboard controller: FSM states,
// score width/limit and the display-slot to one-hot enable mapping.
package placar_pkg;

  localparam int SCORE_W = 7;
  localparam logic [SCORE_W-1:0] MAX_PLACAR = 7'd99;

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    APLICA        = 2'd1,
    ESPERA_SOLTAR = 2'd2
  } estado_t;

  // Display enables, one per scan slot
  localparam logic [3:0] DISP_A_DEZ = 4'b0001;
  localparam logic [3:0] DISP_A_UNI = 4'b0010;
  localparam logic [3:0] DISP_B_DEZ = 4'b0100;
  localparam logic [3:0] DISP_B_UNI = 4'b1000;

  function automatic logic [3:0] slot_onehot(input logic [1:0] slot);
    logic [3:0] oh;
    case (slot)
      2'd0:    oh = DISP_A_DEZ;
      2'd1:    oh = DISP_A_UNI;
      2'd2:    oh = DISP_B_DEZ;
      default: oh = DISP_B_UNI;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/placar_scan.sv
// Display scan: prescaler, 2-bit slot counter, binary-to-BCD split of both
// scores and registered one-hot enable / BCD digit outputs.
module placar_scan
  import placar_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [SCORE_W-1:0] i_placar_a,
  input  logic [SCORE_W-1:0] i_placar_b,
  output logic [3:0]         o_escolha,
  output logic [3:0]         o_digito
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] r_pre;
  logic [1:0]    r_slot;
  logic [3:0]    r_escolha;
  logic [3:0]    r_digito;

  logic          w_wrap;
  logic [1:0]    w_slot_prox;
  logic [7:0]    w_bcd_a;
  logic [7:0]    w_bcd_b;
  logic [3:0]    w_digito;

  // Scores are at most 99, so nine conditional subtractions of 10 suffice
  function automatic logic [7:0] bin2bcd(input logic [SCORE_W-1:0] v);
    logic [3:0]         dez;
    logic [SCORE_W-1:0] resto;
    dez   = 4'd0;
    resto = v;
    for (int t = 0; t < 9; t++) begin
      if (resto >= 7'd10) begin
        resto = resto - 7'd10;
        dez   = dez + 4'd1;
      end
    end
    return {dez, resto[3:0]};
  endfunction

  // Next slot and the digit that belongs to it
  always_comb begin
    w_wrap      = (r_pre == PRE_MAX);
    w_slot_prox = w_wrap ? r_slot + 2'd1 : r_slot;
    w_bcd_a     = bin2bcd(i_placar_a);
    w_bcd_b     = bin2bcd(i_placar_b);
    case (w_slot_prox)
      2'd0:    w_digito = w_bcd_a[7:4];
      2'd1:    w_digito = w_bcd_a[3:0];
      2'd2:    w_digito = w_bcd_b[7:4];
      default: w_digito = w_bcd_b[3:0];
    endcase
  end

  // Prescaler, slot and registered outputs; outputs are loaded from the
  // next slot so enable and digit change on the same edge as the slot
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pre     <= '0;
      r_slot    <= 2'd0;
      r_escolha <= DISP_A_DEZ;
      r_digito  <= 4'd0;
    end else begin
      r_pre     <= w_wrap ? '0 : r_pre + PW'(1);
      r_slot    <= w_slot_prox;
      r_escolha <= slot_onehot(w_slot_prox);
      r_digito  <= w_digito;
    end
  end

  assign o_escolha = r_escolha;
  assign o_digito  = r_digito;

endmodule

// File: rtl/placar_controle.sv
// Basketball scoreboard sequencing controller. Owns both team scores,
// converts each button press into one add/subtract, refuses results outside
// 0..99 (buzzer for additions, led for subtractions) and drives the display
// scan. Optional build macro PLACAR_DEBOUNCE_EN inserts a per-button
// debouncer between the synchronizer and the FSM.
module placar_controle
  import placar_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int BUZZ_LEN   = 25000000,
  parameter int DEB_CYCLES = 500000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         cBotoes,
  input  logic               chaveNP,
  input  logic               chaveTime,
  output logic [SCORE_W-1:0] placarA,
  output logic [SCORE_W-1:0] placarB,
  output logic [3:0]         digitoBCD,
  output logic [3:0]         escolhaDisplay,
  output logic               buzzer,
  output logic               led
);

  generate
    if (SCAN_DIV < 1 || BUZZ_LEN < 1 || DEB_CYCLES < 1) begin : g_param_invalid
      $error("placar_controle: SCAN_DIV, BUZZ_LEN and DEB_CYCLES must be >= 1");
    end
  endgenerate

  localparam int BW = $clog2(BUZZ_LEN + 1);

  // Synchronizers
  logic [2:0] r_bot_s1, r_bot_s2;
  logic       r_np_s1, r_np_s2;
  logic       r_time_s1, r_time_s2;

  logic [2:0] w_bot;

  // FSM and latched operation
  estado_t    r_estado, w_estado_prox;
  logic       w_latch, w_aplica;
  logic [1:0] w_delta;
  logic [1:0] r_delta;
  logic       r_op;
  logic       r_time;

  // Datapath
  logic [SCORE_W-1:0] r_placar_a, r_placar_b;
  logic [SCORE_W-1:0] w_sel;
  logic [7:0]         w_soma;
  logic               w_soma_ok;
  logic               w_sub_ok;
  logic [SCORE_W-1:0] w_dif;
  logic               r_led;
  logic [BW-1:0]      r_buzz_cnt;

  // Two-flop synchronizers for buttons and switches
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bot_s1  <= 3'b000;
      r_bot_s2  <= 3'b000;
      r_np_s1   <= 1'b0;
      r_np_s2   <= 1'b0;
      r_time_s1 <= 1'b0;
      r_time_s2 <= 1'b0;
    end else begin
      r_bot_s1  <= cBotoes;
      r_bot_s2  <= r_bot_s1;
      r_np_s1   <= chaveNP;
      r_np_s2   <= r_np_s1;
      r_time_s1 <= chaveTime;
      r_time_s2 <= r_time_s1;
    end
  end

`ifdef PLACAR_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);

  generate
    for (genvar g = 0; g < 3; g++) begin : g_deb
      logic          r_q;
      logic [DW-1:0] r_cnt;

      // Output flips only after DEB_CYCLES consecutive samples at the new level
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_q   <= 1'b0;
          r_cnt <= '0;
        end else if (r_bot_s2[g] == r_q) begin
          r_cnt <= '0;
        end else if (r_cnt == DW'(DEB_CYCLES - 1)) begin
          r_q   <= r_bot_s2[g];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + DW'(1);
        end
      end

      assign w_bot[g] = r_q;
    end
  endgenerate
`else
  assign w_bot = r_bot_s2;
`endif

  // Highest pressed button wins; simultaneous presses count once
  always_comb begin
    if (w_bot[2])      w_delta = 2'd3;
    else if (w_bot[1]) w_delta = 2'd2;
    else               w_delta = 2'd1;
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= OCIOSO;
    else       r_estado <= w_estado_prox;
  end

  // FSM next state: one APLICA cycle per press, then wait for release
  always_comb begin
    w_estado_prox = r_estado;
    w_latch       = 1'b0;
    w_aplica      = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (|w_bot) begin
          w_latch       = 1'b1;
          w_estado_prox = APLICA;
        end
      end
      APLICA: begin
        w_aplica      = 1'b1;
        w_estado_prox = ESPERA_SOLTAR;
      end
      ESPERA_SOLTAR: begin
        if (!(|w_bot)) w_estado_prox = OCIOSO;
      end
      default: w_estado_prox = OCIOSO;
    endcase
  end

  // Range checks on the selected score; sum is 8 bits so it cannot wrap
  always_comb begin
    w_sel     = r_time ? r_placar_b : r_placar_a;
    w_soma    = {1'b0, w_sel} + {6'd0, r_delta};
    w_soma_ok = (w_soma <= {1'b0, MAX_PLACAR});
    w_sub_ok  = ({5'd0, r_delta} <= w_sel);
    w_dif     = w_sel - {5'd0, r_delta};
  end

  // Latch the operation at press time and apply it in APLICA
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_delta    <= 2'd0;
      r_op       <= 1'b0;
      r_time     <= 1'b0;
      r_placar_a <= '0;
      r_placar_b <= '0;
      r_led      <= 1'b0;
    end else begin
      if (w_latch) begin
        r_delta <= w_delta;
        r_op    <= r_np_s2;
        r_time  <= r_time_s2;
      end
      if (w_aplica) begin
        if (!r_op) begin
          if (w_soma_ok) begin
            if (r_time) r_placar_b <= w_soma[SCORE_W-1:0];
            else        r_placar_a <= w_soma[SCORE_W-1:0];
            r_led <= 1'b0;
          end
        end else begin
          if (w_sub_ok) begin
            if (r_time) r_placar_b <= w_dif;
            else        r_placar_a <= w_dif;
            r_led <= 1'b0;
          end else begin
            r_led <= 1'b1;
          end
        end
      end
    end
  end

  // Buzzer countdown, reloaded by every refused addition
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                               r_buzz_cnt <= '0;
    else if (w_aplica && !r_op && !w_soma_ok) r_buzz_cnt <= BW'(BUZZ_LEN);
    else if (r_buzz_cnt != '0)               r_buzz_cnt <= r_buzz_cnt - BW'(1);
  end

  placar_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clock      (clock),
    .reset      (reset),
    .i_placar_a (r_placar_a),
    .i_placar_b (r_placar_b),
    .o_escolha  (escolhaDisplay),
    .o_digito   (digitoBCD)
  );

  assign placarA = r_placar_a;
  assign placarB = r_placar_b;
  assign buzzer  = (r_buzz_cnt != '0);
  assign led     = r_led;

endmodule

// File: tb/tb_placar_controle.sv
// Self-checking bench for placar_controle: reset/scan sequence, a table of
// press vectors, hand-written corner sequences and a random run against a
// rule-level score model.
module tb_placar_controle;

  localparam int SCAN_DIV   = 4;
  localparam int BUZZ_LEN   = 5;
  localparam int DEB_CYCLES = 8;
`ifdef PLACAR_DEBOUNCE_EN
  localparam int EXTRA = DEB_CYCLES;
`else
  localparam int EXTRA = 0;
`endif
  // ticks from setting a button until the score shows the result
  localparam int LAT = 4 + EXTRA;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] cBotoes = 3'b000;
  logic       chaveNP = 1'b0;
  logic       chaveTime = 1'b0;
  logic [6:0] placarA, placarB;
  logic [3:0] digitoBCD, escolhaDisplay;
  logic       buzzer, led;

  placar_controle #(
    .SCAN_DIV   (SCAN_DIV),
    .BUZZ_LEN   (BUZZ_LEN),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cBotoes        (cBotoes),
    .chaveNP        (chaveNP),
    .chaveTime      (chaveTime),
    .placarA        (placarA),
    .placarB        (placarB),
    .digitoBCD      (digitoBCD),
    .escolhaDisplay (escolhaDisplay),
    .buzzer         (buzzer),
    .led            (led)
  );

  always #5 clock = ~clock;

  // edges since reset released: defines which display slot should be lit
  int edge_cnt;
  always @(posedge clock or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  int total = 0;
  int bad   = 0;
  int mA, mB, mled;

  typedef struct {
    logic       team;
    logic       np;
    logic [2:0] bits;
    int         expA;
    int         expB;
    int         expLed;
  } vec_t;

  vec_t tab [9];

  task automatic chk(input string nome, input logic [31:0] got, input int exp);
    total++;
    if (got !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nome, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int exp_digit(input int slot);
    case (slot)
      0:       return mA / 10;
      1:       return mA % 10;
      2:       return mB / 10;
      default: return mB % 10;
    endcase
  endfunction

  task automatic chk_scan(input string nome);
    int slot;
    slot = (edge_cnt / SCAN_DIV) % 4;
    chk({nome, ".esc"}, escolhaDisplay, 1 << slot);
    chk({nome, ".dig"}, digitoBCD, exp_digit(slot));
  endtask

  task automatic chk_state(input string nome);
    chk({nome, ".A"}, placarA, mA);
    chk({nome, ".B"}, placarB, mB);
    chk({nome, ".led"}, led, mled);
    chk_scan(nome);
  endtask

  // Scoring rules applied to the reference model
  task automatic model_apply(input logic team, input logic np, input logic [2:0] bits);
    int d, s;
    d = bits[2] ? 3 : (bits[1] ? 2 : 1);
    s = team ? mB : mA;
    if (!np) begin
      if (s + d <= 99) begin s = s + d; mled = 0; end
    end else begin
      if (d <= s) begin s = s - d; mled = 0; end
      else mled = 1;
    end
    if (team) mB = s; else mA = s;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cBotoes = 3'b000; chaveNP = 1'b0; chaveTime = 1'b0;
    tick(); tick();
    reset = 1'b0;
    mA = 0; mB = 0; mled = 0;
  endtask

  // One complete press: hold, release, wait until FSM is idle again
  task automatic do_press(input logic team, input logic np, input logic [2:0] bits,
                          input int hold, input bit scramble);
    chaveTime = team; chaveNP = np; cBotoes = bits;
    for (int t = 1; t <= hold; t++) begin
      tick();
      if (scramble && t >= LAT - 1) begin
        chaveTime = 1'($urandom % 2);
        chaveNP   = 1'($urandom % 2);
      end
    end
    cBotoes = 3'b000;
    if (scramble) begin
      chaveTime = 1'($urandom % 2);
      chaveNP   = 1'($urandom % 2);
    end
    repeat (LAT + 2) tick();
    model_apply(team, np, bits);
  endtask

  task automatic set_score(input logic team, input int target);
    int d;
    while ((team ? mB : mA) < target) begin
      d = target - (team ? mB : mA);
      do_press(team, 1'b0, (d >= 3) ? 3'b100 : ((d == 2) ? 3'b010 : 3'b001), 1 + EXTRA, 1'b0);
    end
  endtask

  initial begin
    tab[0] = '{1'b0, 1'b0, 3'b100, 3, 0, 0};
    tab[1] = '{1'b1, 1'b0, 3'b001, 3, 1, 0};
    tab[2] = '{1'b0, 1'b1, 3'b010, 1, 1, 0};
    tab[3] = '{1'b0, 1'b1, 3'b100, 1, 1, 1};
    tab[4] = '{1'b0, 1'b1, 3'b001, 0, 1, 0};
    tab[5] = '{1'b1, 1'b0, 3'b111, 0, 4, 0};
    tab[6] = '{1'b1, 1'b1, 3'b011, 0, 2, 0};
    tab[7] = '{1'b1, 1'b1, 3'b100, 0, 2, 1};
    tab[8] = '{1'b0, 1'b0, 3'b110, 3, 2, 0};

    // Reset state and one full scan round
    tick();
    chk("rst.A", placarA, 0);
    chk("rst.B", placarB, 0);
    chk("rst.buzzer", buzzer, 0);
    chk("rst.led", led, 0);
    chk("rst.esc", escolhaDisplay, 4'b0001);
    chk("rst.dig", digitoBCD, 0);
    do_reset();
    for (int n = 1; n <= 4 * SCAN_DIV; n++) begin
      tick();
      chk("scan.esc", escolhaDisplay, 1 << ((n / SCAN_DIV) % 4));
      chk("scan.dig", digitoBCD, 0);
      chk("scan.A", placarA, 0);
    end

    // Vector table
    do_reset();
    for (int i = 0; i < 9; i++) begin
      do_press(tab[i].team, tab[i].np, tab[i].bits, 2 + EXTRA, 1'b1);
      chk("tab.A", placarA, tab[i].expA);
      chk("tab.B", placarB, tab[i].expB);
      chk("tab.led", led, tab[i].expLed);
      chk_scan("tab");
    end

    // Hold bit2 for 20 cycles: A becomes 3 at the expected edge and stays
    do_reset();
    chaveTime = 1'b0; chaveNP = 1'b0; cBotoes = 3'b100;
    for (int t = 1; t <= 20 + EXTRA; t++) begin
      tick();
      chk("hold.A", placarA, (t >= LAT) ? 3 : 0);
      chk("hold.B", placarB, 0);
    end
    cBotoes = 3'b000;
    repeat (LAT + 2) tick();
    mA = 3;
    chk_state("hold.end");

    // Refused addition at B=98: buzzer exactly BUZZ_LEN cycles
    do_reset();
    set_score(1'b1, 98);
    chk_state("b98");
    chaveTime = 1'b1; chaveNP = 1'b0; cBotoes = 3'b010;
    repeat (LAT - 1) tick();
    chk("buzz.pre", buzzer, 0);
    for (int i = 0; i < BUZZ_LEN; i++) begin
      tick();
      chk("buzz.on", buzzer, 1);
    end
    tick();
    chk("buzz.off", buzzer, 0);
    chk("buzz.B", placarB, 98);
    chk("buzz.led", led, 0);
    cBotoes = 3'b000;
    repeat (LAT + 2) tick();

    // Refused then accepted subtraction at A=1
    do_reset();
    set_score(1'b0, 1);
    do_press(1'b0, 1'b1, 3'b010, 1 + EXTRA, 1'b0);
    chk("sub.refA", placarA, 1);
    chk("sub.refled", led, 1);
    do_press(1'b0, 1'b1, 3'b001, 1 + EXTRA, 1'b0);
    chk("sub.okA", placarA, 0);
    chk("sub.okled", led, 0);

    // Simultaneous bit0+bit2 at A=10, chaveTime toggled while held
    do_reset();
    set_score(1'b0, 10);
    chaveTime = 1'b0; chaveNP = 1'b0; cBotoes = 3'b101;
    for (int t = 1; t <= LAT + 6; t++) begin
      tick();
      if (t >= LAT) begin
        chk("multi.A", placarA, 13);
        chaveTime = ~chaveTime;
      end
    end
    cBotoes = 3'b000;
    repeat (LAT + 2) tick();
    model_apply(1'b0, 1'b0, 3'b101);
    chk_state("multi.end");

    // Reset during a held press, button still held on release
    do_reset();
    chaveTime = 1'b0; chaveNP = 1'b0; cBotoes = 3'b001;
    repeat (LAT) tick();
    chk("rmid.A1", placarA, 1);
    reset = 1'b1;
    #1;
    chk("rmid.clr", placarA, 0);
    tick();
    reset = 1'b0;
    repeat (LAT - 1) tick();
    chk("rmid.pre", placarA, 0);
    tick();
    chk("rmid.A2", placarA, 1);
    cBotoes = 3'b000;
    repeat (LAT + 2) tick();
    mA = 1; mB = 0; mled = 0;
    chk_state("rmid.end");

`ifdef PLACAR_DEBOUNCE_EN
    // Short glitch ignored, long hold counted once
    do_reset();
    chaveTime = 1'b0; chaveNP = 1'b0; cBotoes = 3'b001;
    repeat (5) tick();
    cBotoes = 3'b000;
    repeat (20) tick();
    chk("deb.glitch", placarA, 0);
    cBotoes = 3'b001;
    repeat (12) tick();
    cBotoes = 3'b000;
    repeat (20) tick();
    chk("deb.hold", placarA, 1);
`endif

    // Random presses against the rule model
    do_reset();
    for (int i = 0; i < 120; i++) begin
      do_press(1'($urandom % 2), 1'(($urandom % 4) == 0), 3'($urandom_range(1, 7)),
               EXTRA + int'($urandom_range(1, 6)), 1'b1);
      chk_state("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
